itlb_ptw: RTL

Frontend page-table walker that services instruction-TLB misses. It accepts a missing 20-bit VPN from the TLB and performs an Sv32-style two-level walk over a request/response memory port. It returns a one-cycle fill (PPN, permissions, PCD) for the TLB to write into a free entry, or a one-cycle fault that the TLB converts into its `exception`. It sits directly downstream of `tlb_TOP` on the miss path and upstream of the TLB's fill port.

---
 rtl/itlb_ptw.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/itlb_ptw.sv
// Instruction-TLB page-table walker: two-level Sv32-style walk returning a one-cycle fill or fault.
// Optional megapage leaves at level 1 are enabled by defining PTW_SUPERPAGE_EN.
module itlb_ptw #(
  parameter int XLEN        = 32,
  parameter int VPN_WIDTH   = 20,
  parameter int PPN_WIDTH   = 20,
  parameter int PAGE_OFFSET = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [21:0]          satp_ppn,
  input  logic                 miss_valid,
  output logic                 miss_ready,
  input  logic [VPN_WIDTH-1:0] miss_vpn,
  input  logic                 flush,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [XLEN-1:0]      mem_req_addr,
  input  logic                 mem_resp_valid,
  input  logic [XLEN-1:0]      mem_resp_data,
  output logic                 fill_valid,
  output logic [VPN_WIDTH-1:0] fill_vpn,
  output logic [PPN_WIDTH-1:0] fill_ppn,
  output logic [3:0]           fill_perm,
  output logic                 fill_pcd,
  output logic                 fault_valid,
  output logic [VPN_WIDTH-1:0] fault_vpn
);

  localparam int HALF = VPN_WIDTH / 2;

  typedef enum logic [2:0] {
    IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DONE, DRAIN
  } state_t;

  state_t               state_reg;
  logic                 miss_ready_reg;
  logic                 mem_req_valid_reg;
  logic [XLEN-1:0]      mem_req_addr_reg;
  logic [VPN_WIDTH-1:0] vpn_reg;
  logic                 fill_valid_reg;
  logic [VPN_WIDTH-1:0] fill_vpn_reg;
  logic [PPN_WIDTH-1:0] fill_ppn_reg;
  logic [3:0]           fill_perm_reg;
  logic                 fill_pcd_reg;
  logic                 fault_valid_reg;
  logic [VPN_WIDTH-1:0] fault_vpn_reg;

  // PTE decode of the word currently on the response bus
  logic                 pte_invalid;
  logic                 pte_leaf;
  logic [3:0]           pte_perm;
  logic                 pte_pcd;
  logic [PPN_WIDTH-1:0] l0_leaf_ppn;
  logic                 l1_leaf_ok;
  logic [PPN_WIDTH-1:0] l1_leaf_ppn;
  logic [XLEN-1:0]      l1_addr;
  logic [XLEN-1:0]      l0_addr;
  logic                 unused_bits;

  assign pte_invalid = !mem_resp_data[0] || (!mem_resp_data[1] && mem_resp_data[2]);
  assign pte_leaf    = mem_resp_data[1] | mem_resp_data[3];
  assign pte_perm    = mem_resp_data[4:1];
  assign pte_pcd     = mem_resp_data[8];
  assign l0_leaf_ppn = mem_resp_data[29:10];

  // Address arithmetic wraps at 32 bits; upper root/PTE PPN bits fall off the top.
  assign l1_addr = {satp_ppn[XLEN-PAGE_OFFSET-1:0], {PAGE_OFFSET{1'b0}}}
                 + XLEN'({miss_vpn[VPN_WIDTH-1:HALF], 2'b00});
  assign l0_addr = {mem_resp_data[29:10], {PAGE_OFFSET{1'b0}}}
                 + XLEN'({vpn_reg[HALF-1:0], 2'b00});

`ifdef PTW_SUPERPAGE_EN
  assign l1_leaf_ok  = (mem_resp_data[19:10] == 10'd0);
  assign l1_leaf_ppn = {mem_resp_data[29:20], vpn_reg[HALF-1:0]};
`else
  assign l1_leaf_ok  = 1'b0;
  assign l1_leaf_ppn = mem_resp_data[29:10];
`endif

  assign unused_bits = &{1'b0, satp_ppn[21:20], mem_resp_data[31:30],
                         mem_resp_data[9], mem_resp_data[7:5]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      miss_ready_reg    <= 1'b1;
      mem_req_valid_reg <= 1'b0;
      mem_req_addr_reg  <= '0;
      vpn_reg           <= '0;
      fill_valid_reg    <= 1'b0;
      fill_vpn_reg      <= '0;
      fill_ppn_reg      <= '0;
      fill_perm_reg     <= '0;
      fill_pcd_reg      <= 1'b0;
      fault_valid_reg   <= 1'b0;
      fault_vpn_reg     <= '0;
    end else begin
      fill_valid_reg  <= 1'b0;
      fault_valid_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (miss_valid && !flush) begin
            vpn_reg           <= miss_vpn;
            mem_req_addr_reg  <= l1_addr;
            mem_req_valid_reg <= 1'b1;
            miss_ready_reg    <= 1'b0;
            state_reg         <= L1_REQ;
          end
        end
        L1_REQ, L0_REQ: begin
          if (flush) begin
            mem_req_valid_reg <= 1'b0;
            miss_ready_reg    <= 1'b1;
            state_reg         <= IDLE;
          end else if (mem_req_ready) begin
            mem_req_valid_reg <= 1'b0;
            state_reg         <= (state_reg == L1_REQ) ? L1_WAIT : L0_WAIT;
          end
        end
        L1_WAIT: begin
          if (flush) begin
            // A response arriving with the flush is already consumed, nothing to drain.
            if (mem_resp_valid) begin
              miss_ready_reg <= 1'b1;
              state_reg      <= IDLE;
            end else begin
              state_reg <= DRAIN;
            end
          end else if (mem_resp_valid) begin
            if (pte_invalid || (pte_leaf && !l1_leaf_ok)) begin
              fault_valid_reg <= 1'b1;
              fault_vpn_reg   <= vpn_reg;
              state_reg       <= DONE;
            end else if (!pte_leaf) begin
              mem_req_addr_reg  <= l0_addr;
              mem_req_valid_reg <= 1'b1;
              state_reg         <= L0_REQ;
            end else begin
              fill_valid_reg <= 1'b1;
              fill_vpn_reg   <= vpn_reg;
              fill_ppn_reg   <= l1_leaf_ppn;
              fill_perm_reg  <= pte_perm;
              fill_pcd_reg   <= pte_pcd;
              state_reg      <= DONE;
            end
          end
        end
        L0_WAIT: begin
          if (flush) begin
            if (mem_resp_valid) begin
              miss_ready_reg <= 1'b1;
              state_reg      <= IDLE;
            end else begin
              state_reg <= DRAIN;
            end
          end else if (mem_resp_valid) begin
            if (pte_invalid || !pte_leaf) begin
              fault_valid_reg <= 1'b1;
              fault_vpn_reg   <= vpn_reg;
            end else begin
              fill_valid_reg <= 1'b1;
              fill_vpn_reg   <= vpn_reg;
              fill_ppn_reg   <= l0_leaf_ppn;
              fill_perm_reg  <= pte_perm;
              fill_pcd_reg   <= pte_pcd;
            end
            state_reg <= DONE;
          end
        end
        DONE: begin
          miss_ready_reg <= 1'b1;
          state_reg      <= IDLE;
        end
        DRAIN: begin
          if (mem_resp_valid) begin
            miss_ready_reg <= 1'b1;
            state_reg      <= IDLE;
          end
        end
        default: begin
          miss_ready_reg    <= 1'b1;
          mem_req_valid_reg <= 1'b0;
          state_reg         <= IDLE;
        end
      endcase
    end
  end

  assign miss_ready    = miss_ready_reg;
  assign mem_req_valid = mem_req_valid_reg;
  assign mem_req_addr  = mem_req_addr_reg;
  assign fill_valid    = fill_valid_reg;
  assign fill_vpn      = fill_vpn_reg;
  assign fill_ppn      = fill_ppn_reg;
  assign fill_perm     = fill_perm_reg;
  assign fill_pcd      = fill_pcd_reg;
  assign fault_valid   = fault_valid_reg;
  assign fault_vpn     = fault_vpn_reg;

endmodule
